// File: rtl/vga_led_avalon_writer.sv
// rtl/vga_led_avalon_writer.sv - Avalon-MM master serializing game state into the VGA LED register file
module vga_led_avalon_writer #(
    parameter bit SKIP_UNCHANGED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [15:0] x_pillar1,
    input  logic [15:0] x_pillar2,
    input  logic [15:0] x_pillar3,
    input  logic [7:0]  h_pillar1,
    input  logic [7:0]  h_pillar2,
    input  logic [7:0]  h_pillar3,
    input  logic [15:0] score,
    input  logic [7:0]  move,
    input  logic [15:0] bird,
    input  logic [7:0]  game_info1,
    input  logic [7:0]  game_info2,
    output logic [3:0]  avm_address,
    output logic [7:0]  avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [15:0] frames_sent
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, FIN} state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0][7:0] snap_q, last_q, cap;
    logic             last_valid_q;
    logic             overrun_q;
    logic [15:0]      frames_q;
    logic             last_byte, skip_byte, accept;

    // Element 0 sits in the rightmost slot, so register index equals packed index.
    assign cap = {game_info2, game_info1, bird[7:0], bird[15:8], move,
                  score[7:0], score[15:8], h_pillar3, h_pillar2, h_pillar1,
                  x_pillar3[7:0], x_pillar3[15:8], x_pillar2[7:0], x_pillar2[15:8],
                  x_pillar1[7:0], x_pillar1[15:8]};

    assign last_byte = (idx_q == 4'd15);
    assign skip_byte = SKIP_UNCHANGED && last_valid_q && (snap_q[idx_q] == last_q[idx_q]);
    assign accept    = (state_q == WRITE) && !avm_waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            snap_q       <= '0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frames_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= frame_tick && (state_q != IDLE);
            if (state_q == IDLE && frame_tick) begin
                snap_q <= cap;
            end
            if (accept) begin
                last_q[idx_q] <= snap_q[idx_q];
            end
            if (state_q == FIN) begin
                frames_q     <= frames_q + 16'd1;
                last_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SCAN;
                    idx_d   = 4'd0;
                end
            end
            SCAN: begin
                if (skip_byte) begin
                    if (last_byte) begin
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    if (last_byte) begin
                        state_d = FIN;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + 4'd1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        avm_write      = (state_q == WRITE);
        avm_chipselect = (state_q == WRITE);
        avm_address    = (state_q == WRITE) ? idx_q : 4'd0;
        avm_writedata  = (state_q == WRITE) ? snap_q[idx_q] : 8'd0;
        busy           = (state_q != IDLE);
        done           = (state_q == FIN);
        overrun        = overrun_q;
        frames_sent    = frames_q;
    end

endmodule
